// File: rtl/usb_slave_fifo_tx.sv
`default_nettype none
// usb_slave_fifo_tx -- FX2 slave-FIFO write master: sync header, then a frame in endpoint packets
// with a PKTEND commit for a trailing short packet. Ready/valid payload source. Rev 1.0
module usb_slave_fifo_tx #(
  parameter int                DATA_W      = 16,
  parameter int                PKT_WORDS   = 256,
  parameter int                HDR_WORDS   = 256,
  parameter logic [DATA_W-1:0] SYNC_EVEN   = 16'h7CD2,
  parameter logic [DATA_W-1:0] SYNC_ODD    = 16'h15D8,
  parameter int                FRAME_WORDS = 307200,
  parameter logic [1:0]        EP_ADDR     = 2'b10,
  parameter int                CNT_W       = 20
) (
  input  logic              usb_clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic              flag_full,
  output logic [DATA_W-1:0] USB_DATA,
  output logic [1:0]        USB_FIFO_ADR,
  output logic              USB_SLWR,
  output logic              USB_SLRD,
  output logic              USB_SLOE,
  output logic              PKTEND,
  output logic              busy,
  output logic              frame_done,
  output logic              abort
);

  localparam int PKT_CW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  // Wide enough to hold HDR_WORDS itself so the header index never wraps.
  localparam int HDR_CW = $clog2(HDR_WORDS + 2);

  localparam logic [PKT_CW-1:0] PKT_LAST  = PKT_CW'(PKT_WORDS - 1);
  localparam logic [HDR_CW-1:0] HDR_LAST  = HDR_CW'(HDR_WORDS - 1);
  localparam logic [CNT_W-1:0]  FRM_LAST  = CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0]  FRM_TOTAL = CNT_W'(FRAME_WORDS);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_HDR  = 3'd1,
    HEADER    = 3'd2,
    WAIT_ROOM = 3'd3,
    STREAM    = 3'd4,
    SHORT_GAP = 3'd5,
    COMMIT    = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t              state, state_nxt;
  logic [PKT_CW-1:0]   pkt_cnt, pkt_nxt;
  logic [HDR_CW-1:0]   hdr_cnt, hdr_nxt;
  logic [CNT_W-1:0]    frm_cnt, frm_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                slwr_nxt;
  logic                pktend_nxt;
  logic                done_nxt;
  logic                abort_nxt;
  logic                xfer;

  assign USB_FIFO_ADR = EP_ADDR;
  assign USB_SLRD     = 1'b1;
  assign USB_SLOE     = 1'b1;
  assign busy         = (state != IDLE);
  assign src_ready    = (state == STREAM) && (frm_cnt < FRM_TOTAL);
  assign xfer         = src_valid && src_ready;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pkt_cnt    <= '0;
      hdr_cnt    <= '0;
      frm_cnt    <= '0;
      USB_DATA   <= '0;
      USB_SLWR   <= 1'b1;
      PKTEND     <= 1'b1;
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state      <= state_nxt;
      pkt_cnt    <= pkt_nxt;
      hdr_cnt    <= hdr_nxt;
      frm_cnt    <= frm_nxt;
      USB_DATA   <= data_nxt;
      USB_SLWR   <= slwr_nxt;
      PKTEND     <= pktend_nxt;
      frame_done <= done_nxt;
      abort      <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pkt_nxt    = pkt_cnt;
    hdr_nxt    = hdr_cnt;
    frm_nxt    = frm_cnt;
    data_nxt   = USB_DATA;
    slwr_nxt   = 1'b1;
    pktend_nxt = 1'b1;
    done_nxt   = 1'b0;
    abort_nxt  = 1'b0;

    unique case (state)
      IDLE: ;
      WAIT_HDR:  if (!flag_full) state_nxt = HEADER;
      WAIT_ROOM: if (!flag_full) state_nxt = STREAM;
      HEADER: begin
        slwr_nxt = 1'b0;
        data_nxt = hdr_cnt[0] ? SYNC_ODD : SYNC_EVEN;
        hdr_nxt  = hdr_cnt + 1'b1;
        pkt_nxt  = pkt_cnt + 1'b1;
        if (hdr_cnt == HDR_LAST) begin
          state_nxt = WAIT_ROOM;
          pkt_nxt   = '0;
        end else if (pkt_cnt == PKT_LAST) begin
          state_nxt = WAIT_HDR;
          pkt_nxt   = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          slwr_nxt = 1'b0;
          data_nxt = src_data;
          frm_nxt  = frm_cnt + 1'b1;
          pkt_nxt  = pkt_cnt + 1'b1;
          if (pkt_cnt == PKT_LAST) pkt_nxt = '0;
          if (frm_cnt == FRM_LAST) begin
            // A frame ending exactly on a packet boundary needs no explicit commit.
            if (pkt_cnt == PKT_LAST) state_nxt = DONE;
            else                     state_nxt = SHORT_GAP;
          end else if (pkt_cnt == PKT_LAST) begin
            state_nxt = WAIT_ROOM;
          end
        end
      end
      SHORT_GAP: state_nxt = COMMIT;
      COMMIT: begin
        pktend_nxt = 1'b0;
        state_nxt  = DONE;
      end
      DONE: begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A new frame overrides sequencing; the write already decided above still goes out.
    if (frame_start) begin
      abort_nxt = (state != IDLE);
      pkt_nxt   = '0;
      hdr_nxt   = '0;
      frm_nxt   = '0;
      if (HDR_WORDS == 0) state_nxt = WAIT_ROOM;
      else                state_nxt = WAIT_HDR;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_slave_fifo_tx.sv
`default_nettype none
// tb_usb_slave_fifo_tx -- scaled-down frames (8-word packets) on two instances: one ending in a
// short packet with header, one ending on a full packet without header. Rev 1.0
module tb_usb_slave_fifo_tx;

  localparam int PKT     = 8;
  localparam int HDR     = 8;
  localparam int FRAME   = 20;
  localparam int FRAME_F = 16;
  localparam logic [15:0] SYNC_EVEN = 16'h7CD2;
  localparam logic [15:0] SYNC_ODD  = 16'h15D8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        src_valid = 1'b0;
  logic        flag_full = 1'b0;
  logic [15:0] src_data = '0;

  logic        m_ready, m_slwr, m_slrd, m_sloe, m_pktend, m_busy, m_done, m_abort;
  logic [15:0] m_data;
  logic [1:0]  m_adr;
  logic        f_ready, f_slwr, f_slrd, f_sloe, f_pktend, f_busy, f_done, f_abort;
  logic [15:0] f_data;
  logic [1:0]  f_adr;

  always #5 clk = ~clk;

  usb_slave_fifo_tx #(
    .DATA_W(16), .PKT_WORDS(PKT), .HDR_WORDS(HDR), .FRAME_WORDS(FRAME),
    .EP_ADDR(2'b10), .CNT_W(6)
  ) u_dut (
    .usb_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .src_data(src_data),
    .src_valid(src_valid), .src_ready(m_ready), .flag_full(flag_full), .USB_DATA(m_data),
    .USB_FIFO_ADR(m_adr), .USB_SLWR(m_slwr), .USB_SLRD(m_slrd), .USB_SLOE(m_sloe),
    .PKTEND(m_pktend), .busy(m_busy), .frame_done(m_done), .abort(m_abort)
  );

  usb_slave_fifo_tx #(
    .DATA_W(16), .PKT_WORDS(PKT), .HDR_WORDS(0), .FRAME_WORDS(FRAME_F),
    .EP_ADDR(2'b10), .CNT_W(6)
  ) u_full (
    .usb_clk(clk), .rst_n(rst_n), .frame_start(frame_start), .src_data(src_data),
    .src_valid(src_valid), .src_ready(f_ready), .flag_full(flag_full), .USB_DATA(f_data),
    .USB_FIFO_ADR(f_adr), .USB_SLWR(f_slwr), .USB_SLRD(f_slrd), .USB_SLOE(f_sloe),
    .PKTEND(f_pktend), .busy(f_busy), .frame_done(f_done), .abort(f_abort)
  );

  // Pin monitor: counts strobes and compares every written word against the header
  // pattern or the queue of accepted source words.
  int cyc = 0;
  int w_m = 0, slwr_m = 0, pkt_m = 0, done_m = 0, abort_m = 0, derr_m = 0, fwords_m = 0, left_m = 0;
  int last_slwr_m = 0, pkt_cyc_m = 0, done_cyc_m = 0;
  int w_f = 0, slwr_f = 0, pkt_f = 0, done_f = 0, fwords_f = 0, last_slwr_f = 0, done_cyc_f = 0;
  logic [15:0] acc_q[$];
  logic [15:0] exp_w;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        w_m = 0;
        w_f = 0;
        acc_q.delete();
      end else begin
        if (m_slwr == 1'b0) begin
          slwr_m++;
          last_slwr_m = cyc;
          if (w_m < HDR) begin
            exp_w = w_m[0] ? SYNC_ODD : SYNC_EVEN;
            if (m_data !== exp_w) derr_m++;
          end else if (acc_q.size() == 0) begin
            derr_m++;
          end else begin
            exp_w = acc_q.pop_front();
            if (m_data !== exp_w) derr_m++;
          end
          w_m++;
        end
        if (m_pktend == 1'b0) begin pkt_m++; pkt_cyc_m = cyc; end
        if (m_done) begin done_m++; done_cyc_m = cyc; fwords_m = w_m; left_m = acc_q.size(); end
        if (m_abort) abort_m++;
        if (f_slwr == 1'b0) begin slwr_f++; w_f++; last_slwr_f = cyc; end
        if (f_pktend == 1'b0) pkt_f++;
        if (f_done) begin done_f++; done_cyc_f = cyc; fwords_f = w_f; end
        if (frame_start) begin
          w_m = 0;
          w_f = 0;
          acc_q.delete();
        end
        if (src_valid && m_ready) acc_q.push_back(src_data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int s_slwr_m, s_pkt_m, s_done_m, s_abort_m, s_derr_m, s_slwr_f, s_pkt_f, s_done_f;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_slwr_m = slwr_m; s_pkt_m = pkt_m; s_done_m = done_m; s_abort_m = abort_m;
    s_derr_m = derr_m; s_slwr_f = slwr_f; s_pkt_f = pkt_f; s_done_f = done_f;
  endtask

  task automatic pulse_start(input bit v);
    tick();
    frame_start = 1'b1;
    src_valid   = v;
    src_data    = 16'($urandom);
    tick();
    frame_start = 1'b0;
  endtask

  task automatic stream_until_done(input int pct, input bit stall, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      src_valid = ($urandom_range(99) < pct);
      src_data  = 16'($urandom);
      flag_full = stall && ((k % 9) < 5);
      tick();
      if (done_m > s_done_m && done_f > s_done_f) begin
        ok = 1'b1;
        break;
      end
    end
    src_valid = 1'b0;
    flag_full = 1'b0;
  endtask

  typedef struct {
    int valid_pct;
    bit stall;
    int exp_words_m;
    int exp_pkt_m;
    int exp_words_f;
    int exp_pkt_f;
  } row_t;

  row_t rows[5];
  bit   ok;
  int   k_wait;

  initial begin
    rows[0] = '{100, 1'b0, HDR + FRAME, 1, FRAME_F, 0};
    rows[1] = '{30,  1'b0, HDR + FRAME, 1, FRAME_F, 0};
    rows[2] = '{70,  1'b1, HDR + FRAME, 1, FRAME_F, 0};
    rows[3] = '{100, 1'b1, HDR + FRAME, 1, FRAME_F, 0};
    rows[4] = '{50,  1'b1, HDR + FRAME, 1, FRAME_F, 0};

    // Reset values
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_slwr",   int'(m_slwr), 1);
    check("rst_slrd",   int'(m_slrd), 1);
    check("rst_sloe",   int'(m_sloe), 1);
    check("rst_pktend", int'(m_pktend), 1);
    check("rst_data",   int'(m_data), 0);
    check("rst_adr",    int'(m_adr), 2);
    check("rst_ready",  int'(m_ready), 0);
    check("rst_busy",   int'(m_busy), 0);
    check("rst_done",   int'(m_done), 0);
    check("rst_abort",  int'(m_abort), 0);
    rst_n = 1'b1;

    // Idle block ignores a valid source
    src_valid = 1'b1;
    snap();
    repeat (4) tick();
    check("idle_no_writes", slwr_m - s_slwr_m, 0);
    check("idle_ready", int'(m_ready), 0);
    check("idle_busy",  int'(m_busy), 0);
    src_valid = 1'b0;

    // frame_start while the endpoint is full: waits, then the header starts two pin-cycles later
    snap();
    flag_full = 1'b1;
    pulse_start(1'b1);
    repeat (4) tick();
    check("full_wait_writes", slwr_m - s_slwr_m, 0);
    check("full_wait_busy", int'(m_busy), 1);
    tick();
    flag_full = 1'b0;
    @(negedge clk);
    check("resume_c0_slwr", int'(m_slwr), 1);
    tick();
    @(negedge clk);
    check("resume_c1_slwr", int'(m_slwr), 1);
    tick();
    @(negedge clk);
    check("resume_c2_slwr", int'(m_slwr), 0);
    check("resume_c2_data", int'(m_data), int'(SYNC_EVEN));
    stream_until_done(100, 1'b0, ok);
    repeat (3) tick();
    check("resume_done", int'(ok), 1);
    check("resume_words", fwords_m, HDR + FRAME);
    check("resume_data_err", derr_m - s_derr_m, 0);

    // Table of whole frames under different source and flag behaviour
    for (int i = 0; i < 5; i++) begin
      snap();
      pulse_start(1'b1);
      stream_until_done(rows[i].valid_pct, rows[i].stall, ok);
      repeat (3) tick();
      check($sformatf("r%0d_done_in_budget", i), int'(ok), 1);
      check($sformatf("r%0d_m_words", i), fwords_m, rows[i].exp_words_m);
      check($sformatf("r%0d_m_slwr", i), slwr_m - s_slwr_m, rows[i].exp_words_m);
      check($sformatf("r%0d_m_pktend", i), pkt_m - s_pkt_m, rows[i].exp_pkt_m);
      check($sformatf("r%0d_m_done", i), done_m - s_done_m, 1);
      check($sformatf("r%0d_m_abort", i), abort_m - s_abort_m, 0);
      check($sformatf("r%0d_m_data_err", i), derr_m - s_derr_m, 0);
      check($sformatf("r%0d_m_leftover", i), left_m, 0);
      check($sformatf("r%0d_f_words", i), slwr_f - s_slwr_f, rows[i].exp_words_f);
      check($sformatf("r%0d_f_pktend", i), pkt_f - s_pkt_f, rows[i].exp_pkt_f);
      check($sformatf("r%0d_f_done", i), done_f - s_done_f, 1);
      check($sformatf("r%0d_m_busy_after", i), int'(m_busy), 0);
    end

    // End-of-frame timing: short packet gap/commit versus full-packet finish
    snap();
    pulse_start(1'b1);
    stream_until_done(100, 1'b0, ok);
    repeat (3) tick();
    check("tail_done", int'(ok), 1);
    check("tail_gap_to_pktend", pkt_cyc_m - last_slwr_m, 2);
    check("tail_pktend_to_done", done_cyc_m - pkt_cyc_m, 1);
    check("tail_full_last_to_done", done_cyc_f - last_slwr_f, 1);

    // frame_start in the middle of the payload
    snap();
    pulse_start(1'b1);
    src_valid = 1'b1;
    for (k_wait = 0; k_wait < 500; k_wait++) begin
      src_data = 16'($urandom);
      tick();
      if (w_m >= HDR + 10) break;
    end
    check("abort_reached_word", int'(w_m >= HDR + 10), 1);
    frame_start = 1'b1;
    src_valid   = 1'b0;
    tick();
    frame_start = 1'b0;
    stream_until_done(100, 1'b0, ok);
    repeat (3) tick();
    check("abort_done", int'(ok), 1);
    check("abort_pulses", abort_m - s_abort_m, 1);
    check("abort_pktend", pkt_m - s_pkt_m, 1);
    check("abort_frame_done", done_m - s_done_m, 1);
    check("abort_words", fwords_m, HDR + FRAME);
    check("abort_data_err", derr_m - s_derr_m, 0);

    // Asynchronous reset while streaming
    pulse_start(1'b1);
    src_valid = 1'b1;
    for (k_wait = 0; k_wait < 500; k_wait++) begin
      src_data = 16'($urandom);
      tick();
      if (w_m >= HDR + 3) break;
    end
    #1 rst_n = 1'b0;
    #1;
    check("arst_slwr",   int'(m_slwr), 1);
    check("arst_pktend", int'(m_pktend), 1);
    check("arst_busy",   int'(m_busy), 0);
    check("arst_ready",  int'(m_ready), 0);
    check("arst_data",   int'(m_data), 0);
    tick();
    tick();
    rst_n = 1'b1;
    snap();
    repeat (6) tick();
    check("arst_idle_writes", slwr_m - s_slwr_m, 0);
    check("arst_idle_ready", int'(m_ready), 0);
    check("arst_idle_pktend", pkt_m - s_pkt_m, 0);
    src_valid = 1'b0;

    snap();
    pulse_start(1'b1);
    stream_until_done(60, 1'b1, ok);
    repeat (3) tick();
    check("post_rst_done", int'(ok), 1);
    check("post_rst_words", fwords_m, HDR + FRAME);
    check("post_rst_pktend", pkt_m - s_pkt_m, 1);
    check("post_rst_data_err", derr_m - s_derr_m, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_slave_fifo_tx.md
Name: usb_slave_fifo_tx

Overview:
Parametrised next-generation FX2 slave-FIFO write master for the image path. It replaces the fixed-length, fixed-latency `data_pulse` scheme with a ready/valid source interface. It sends a configurable sync header at frame start, then streams a whole frame in endpoint-sized packets. If the frame length is not a multiple of the packet size, it commits the final short packet with PKTEND. It sits between the DDR3 read-back FIFO and the FX2 pins.

Parameters:
DATA_W, 16, width of USB_DATA and src_data
PKT_WORDS, 256, words per full endpoint packet (512-byte EP6 at 16 bit)
HDR_WORDS, 256, header length in words; 0 disables the header
SYNC_EVEN, 16'h7CD2, header word at even header index
SYNC_ODD, 16'h15D8, header word at odd header index
FRAME_WORDS, 307200, payload words per frame (640x480)
EP_ADDR, 2'b10, value driven on USB_FIFO_ADR (EP6)
CNT_W, 20, width of the frame word counter; must satisfy 2^CNT_W > FRAME_WORDS

Ports:
usb_clk  in  1  FX2 IFCLK; all logic is on its rising edge
rst_n  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse that starts a frame; ignored when it coincides with reset
src_data  in  DATA_W  payload word
src_valid  in  1  src_data is valid
src_ready  out  1  block accepts src_data on this cycle (valid&ready = transfer)
flag_full  in  1  EP6 full flag, already converted to active-high
USB_DATA  out  DATA_W  FIFO data bus, registered
USB_FIFO_ADR  out  2  endpoint select; constant EP_ADDR
USB_SLWR  out  1  active-low write strobe, registered
USB_SLRD  out  1  active-low read strobe; constant 1
USB_SLOE  out  1  active-low output enable; constant 1
PKTEND  out  1  active-low packet commit, registered
busy  out  1  high from frame_start until DONE is exited
frame_done  out  1  one-cycle pulse when the last word or PKTEND has been issued
abort  out  1  one-cycle pulse when frame_start arrives while busy

Behaviour:
- Reset values: USB_SLWR=1, USB_SLRD=1, USB_SLOE=1, PKTEND=1, USB_DATA=0, USB_FIFO_ADR=EP_ADDR, src_ready=0, busy=0, frame_done=0, abort=0, state=IDLE, all counters=0.
- Counters:
  - pkt_cnt: word index within the current packet, range 0..PKT_WORDS-1.
  - hdr_cnt: header word index.
  - frm_cnt: payload words written this frame, CNT_W bits.
  - None of the counters wraps within a frame.
- States: IDLE, WAIT_HDR, HEADER, WAIT_ROOM, STREAM, SHORT_GAP, COMMIT, DONE.
- IDLE: on frame_start, clear all counters, set busy=1, and go to WAIT_HDR (or to WAIT_ROOM if HDR_WORDS=0).
- WAIT_HDR and WAIT_ROOM: stay while flag_full=1. When flag_full=0, go to HEADER or STREAM respectively. flag_full is sampled only in these two states, i.e. only at packet boundaries; the FX2 guarantees room for one whole packet once the flag is clear.
- HEADER: one word per cycle.
  - USB_DATA = SYNC_EVEN when hdr_cnt[0]=0, else SYNC_ODD. USB_SLWR=0 in the same registered cycle.
  - hdr_cnt and pkt_cnt advance every cycle. When pkt_cnt reaches PKT_WORDS-1, return to WAIT_HDR.
  - After word HDR_WORDS-1, go to WAIT_ROOM with pkt_cnt=0.
  - HDR_WORDS must be a multiple of PKT_WORDS; a partial header packet is not supported.
- STREAM:
  - src_ready=1 (combinational from state) while pkt_cnt<PKT_WORDS and frm_cnt<FRAME_WORDS.
  - On valid&ready: register USB_DATA<=src_data and USB_SLWR<=0 for the next cycle, then increment pkt_cnt and frm_cnt.
  - When src_valid=0: USB_SLWR=1 and nothing advances. Source stalls of any length are legal.
  - After word PKT_WORDS-1 of a packet, with the frame not finished, go to WAIT_ROOM.
  - After frame word FRAME_WORDS-1:
    - if that word completed a full packet, go to DONE;
    - otherwise go to SHORT_GAP.
- SHORT_GAP: one cycle with SLWR=1 and PKTEND=1, which meets the FX2 SLWR-to-PKTEND spacing. Then go to COMMIT.
- COMMIT: PKTEND=0 for exactly one cycle, then go to DONE.
- DONE: frame_done=1 for one cycle, busy=0, then go to IDLE.
- Strobe timing: USB_SLWR is low for exactly one cycle per word written. The number of SLWR-low cycles per frame is HDR_WORDS+FRAME_WORDS.
- frame_start while busy:
  - the current write completes (registered strobe);
  - abort=1 for one cycle;
  - no PKTEND is issued for the partial packet;
  - counters clear and the block proceeds as if from IDLE.
- frame_start in IDLE while flag_full=1: the block enters WAIT_HDR and waits there. The frame is not lost.
- Asynchronous reset mid-frame: all outputs go to their reset values immediately, including USB_SLWR=1 and PKTEND=1. No partial commit is issued.

Test Plan:
- Defaults, flag_full=0, src_valid=1: frame_start -> 256 SLWR pulses carrying 7CD2/15D8 alternating, then 307200 data words in 1200 packets; no PKTEND; frame_done once; busy falls after DONE.
- FRAME_WORDS=600, HDR_WORDS=0: -> packets of 256 and 256, then 88 words, one idle cycle, PKTEND low for 1 cycle, then frame_done.
- flag_full asserted at every packet boundary for 5 cycles: -> zero writes while full; writes resume on the cycle after flag_full falls; total word count unchanged.
- src_valid toggling at random 30%: -> USB_DATA sequence equals the accepted src_data sequence exactly; no SLWR pulse without a transfer.
- frame_start at payload word 1000: -> abort pulse, no PKTEND, new header begins; second frame completes normally.
- rst_n low during STREAM: -> SLWR=1, PKTEND=1, busy=0 asynchronously; after release, the block is in IDLE and ignores src_valid until frame_start.
